// File: rtl/register_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : register_arbiter
//  Description : Two-requester arbiter in front of a single register bus.
//                Each accepted transaction (read or write) is issued for one
//                cycle on the bus, then waits READ_LATENCY cycles for the
//                bus read data. That data is returned to the requester that
//                owns the transaction as a one-cycle RdValid strobe. A write
//                returns the register contents seen during its issue cycle,
//                which is the value before the write.
//                Ties between the two requesters alternate. A wins the first
//                tie after reset.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    READ_LATENCY   register-bus read latency in cycles (legal 1..4)
//  Ports
//    ipClk          single clock, rising edge
//    ipReset        asynchronous active-low reset
//    ipA_Valid      requester A request
//    ipA_Address    requester A register address [7:0]
//    ipA_WrData     requester A write data [31:0]
//    ipA_WrEnable   requester A write flag (0 = read)
//    opA_Ready      requester A accept strobe (combinational)
//    opA_RdValid    requester A one-cycle response strobe
//    opA_RdData     requester A response data [31:0]
//    ipB_* / opB_*  requester B, identical to requester A
//    opAddress      register-bus address [7:0]
//    opWrData       register-bus write data [31:0]
//    opWrEnable     register-bus write strobe
//    ipRdData       register-bus read data [31:0]
//    opBusy         high whenever a transaction is in flight
// ============================================================================
module register_arbiter #(
    parameter int READ_LATENCY = 1
) (
    input  logic        ipClk,
    input  logic        ipReset,

    input  logic        ipA_Valid,
    input  logic [7:0]  ipA_Address,
    input  logic [31:0] ipA_WrData,
    input  logic        ipA_WrEnable,
    output logic        opA_Ready,
    output logic        opA_RdValid,
    output logic [31:0] opA_RdData,

    input  logic        ipB_Valid,
    input  logic [7:0]  ipB_Address,
    input  logic [31:0] ipB_WrData,
    input  logic        ipB_WrEnable,
    output logic        opB_Ready,
    output logic        opB_RdValid,
    output logic [31:0] opB_RdData,

    output logic [7:0]  opAddress,
    output logic [31:0] opWrData,
    output logic        opWrEnable,
    input  logic [31:0] ipRdData,

    output logic        opBusy
);

    // Out-of-range latencies are clamped into the legal window so the wait
    // counter can never be asked to count past its width.
    localparam int       c_latency  = (READ_LATENCY < 1) ? 1 :
                                      (READ_LATENCY > 4) ? 4 : READ_LATENCY;
    localparam logic [2:0] c_lastWait = 3'(c_latency - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t      r_state;
    logic [2:0]  r_waitCnt;
    logic        r_lastGrantB;   // 1: B was granted most recently
    logic        r_ownerB;       // 1: transaction in flight belongs to B

    logic        w_idle;
    logic        w_grantA;
    logic        w_grantB;
    logic        w_accept;

    // ------------------------------------------------------------------------
    // Grant selection. A single requester always wins; on a tie the side that
    // was not granted last wins. Ready is also gated by ipReset so that no
    // handshake can be seen while reset is held, even though the state
    // register already reads IDLE.
    // ------------------------------------------------------------------------
    assign w_idle    = (r_state == IDLE);
    assign w_grantA  = ipA_Valid && (!ipB_Valid || r_lastGrantB);
    assign w_grantB  = ipB_Valid && !w_grantA;

    assign opA_Ready = ipReset && w_idle && w_grantA;
    assign opB_Ready = ipReset && w_idle && w_grantB;
    assign w_accept  = opA_Ready || opB_Ready;

    assign opBusy    = !w_idle;

    // ------------------------------------------------------------------------
    // Main FSM with registered bus and response outputs.
    // The bus address/data registers double as the captured request: they are
    // loaded on acceptance, drive the bus in ISSUE, and simply hold afterwards.
    // ------------------------------------------------------------------------
    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            r_state      <= IDLE;
            r_waitCnt    <= 3'd0;
            r_lastGrantB <= 1'b1;
            r_ownerB     <= 1'b0;
            opAddress    <= 8'd0;
            opWrData     <= 32'd0;
            opWrEnable   <= 1'b0;
            opA_RdValid  <= 1'b0;
            opA_RdData   <= 32'd0;
            opB_RdValid  <= 1'b0;
            opB_RdData   <= 32'd0;
        end else begin
            // Response strobes are single-cycle by default.
            opA_RdValid <= 1'b0;
            opB_RdValid <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state      <= ISSUE;
                        r_ownerB     <= opB_Ready;
                        r_lastGrantB <= opB_Ready;
                        if (opB_Ready) begin
                            opAddress  <= ipB_Address;
                            opWrData   <= ipB_WrData;
                            opWrEnable <= ipB_WrEnable;
                        end else begin
                            opAddress  <= ipA_Address;
                            opWrData   <= ipA_WrData;
                            opWrEnable <= ipA_WrEnable;
                        end
                    end
                end

                ISSUE: begin
                    // The write strobe lives for the ISSUE cycle only.
                    r_state    <= WAIT;
                    r_waitCnt  <= 3'd0;
                    opWrEnable <= 1'b0;
                end

                WAIT: begin
                    if (r_waitCnt == c_lastWait) begin
                        // Last WAIT cycle: the bus data now reflects the
                        // ISSUE-cycle read and is handed to the owner.
                        r_state <= IDLE;
                        if (r_ownerB) begin
                            opB_RdData  <= ipRdData;
                            opB_RdValid <= 1'b1;
                        end else begin
                            opA_RdData  <= ipRdData;
                            opA_RdValid <= 1'b1;
                        end
                    end else begin
                        r_waitCnt <= r_waitCnt + 3'd1;
                    end
                end

                default: begin
                    r_state    <= IDLE;
                    opWrEnable <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/register_arbiter.md
REGISTER_ARBITER -- requirements
Module: register_arbiter

Interface
REQ-001 Parameter READ_LATENCY, default 1, SHALL be the register-bus read latency in clock cycles, legal range 1..4.
REQ-002 ipClk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 ipReset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 ipA_Valid  input  1  SHALL be requester A's transaction request.
REQ-005 ipA_Address  input  8  SHALL be requester A's register address.
REQ-006 ipA_WrData  input  32  SHALL be requester A's write data.
REQ-007 ipA_WrEnable  input  1  SHALL be requester A's write flag; 0 means read.
REQ-008 opA_Ready  output  1  SHALL be requester A's accept strobe.
REQ-009 opA_RdValid  output  1  SHALL be requester A's one-cycle response strobe.
REQ-010 opA_RdData  output  32  SHALL be requester A's response data.
REQ-011 Requester B SHALL have ports identical to REQ-004..REQ-010 with prefix B.
REQ-012 opAddress  output  8  SHALL be the register-bus address.
REQ-013 opWrData  output  32  SHALL be the register-bus write data.
REQ-014 opWrEnable  output  1  SHALL be the register-bus write strobe.
REQ-015 ipRdData  input  32  SHALL be the register-bus read data.
REQ-016 opBusy  output  1  SHALL be 1 whenever the state is not IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE and WAIT; IDLE->ISSUE on acceptance, ISSUE->WAIT always, WAIT->IDLE after READ_LATENCY cycles in WAIT.
REQ-018 Handshake SHALL complete when Valid && Ready; Ready is combinational, asserted only in IDLE, and asserted to at most one requester.
REQ-019 Grant: one Valid -> that requester; both Valid -> the requester not granted last; the last-granted register SHALL be set so A wins the first tie after reset.
REQ-020 On acceptance, the address, data, write flag and owner SHALL be registered; the next cycle (ISSUE) drives opAddress and opWrData from them, with opWrEnable = write flag.
REQ-021 opWrEnable SHALL be 1 only during ISSUE of a write; opAddress and opWrData SHALL hold their last values outside ISSUE.
REQ-022 ipRdData SHALL be captured at the end of the last WAIT cycle into the owner's RdData; the owner's RdValid pulses for exactly the following cycle (first IDLE cycle).
REQ-023 The non-owner's RdValid SHALL stay 0; each RdData holds until that requester's next response.
REQ-024 A write SHALL return the register contents read at its ISSUE cycle, which are the pre-write value; exactly one response per accepted transaction.
REQ-025 A new acceptance SHALL be allowed in the cycle carrying the previous RdValid; the sustained rate is one transaction per 2+READ_LATENCY cycles.
REQ-026 With READ_LATENCY=1, the cycle sequence is: accept c0, ISSUE c1, WAIT c2, RdValid c3.
REQ-027 Valid deasserted before acceptance SHALL cancel that request without side effects; inputs are don't-care when they are not being accepted.
REQ-028 Valid from either requester while opBusy=1 SHALL be ignored until IDLE.

Reset
REQ-029 While ipReset=0: state IDLE, opBusy 0, both Ready 0, both RdValid 0, both RdData 0, opAddress 0, opWrData 0, opWrEnable 0, last-granted = B.
REQ-030 Reset asserted mid-transaction SHALL abort it immediately with no RdValid issued, including from ISSUE when opWrEnable drops asynchronously.
REQ-031 After reset release, the first acceptance SHALL occur no earlier than the first rising edge with ipReset=1.

Verification
REQ-032 A writes 0x0000_00A5 to 0x02, then reads 0x02: the write response returns the old value (0 after reset), the read returns 0x0000_00A5, and the cycles match REQ-026.
REQ-033 A and B both Valid every IDLE cycle for 6 transactions: grants alternate A,B,A,B,A,B and every RdValid reaches the correct owner only.
REQ-034 B alone holds Valid continuously: it is accepted every 3 cycles (READ_LATENCY=1) and every 6 cycles with READ_LATENCY=4.
REQ-035 Reset asserted during ISSUE of a write to 0x04: opWrEnable falls asynchronously, no RdValid follows, and a subsequent read of 0x04 shows the unchanged value.
REQ-036 Valid pulsed only during ISSUE/WAIT: it is never accepted and the bus shows no extra opWrEnable.
